// File: rtl/seq_mag_comparator_pkg.sv
// Shared types and helpers for the sequential magnitude comparator.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    REL_EQ,
    REL_GT,
    REL_LT,
    REL_GE
  } rel_t;

  // Number of DIGIT-wide slices needed to cover a WIDTH-bit operand.
  function automatic int ndig(input int width, input int digit);
    return (width + digit - 1) / digit;
  endfunction

endpackage

// File: rtl/seq_mag_comparator_digit_cmp.sv
// Combinational comparison of one DIGIT-bit slice, MSB-first priority.
module digit_cmp #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  output logic             d_eq,
  output logic             d_gt
);

  logic [DIGIT-1:0] w_bitEq;

  assign w_bitEq = x ~^ y;

  // Walk LSB to MSB so the most significant differing bit decides d_gt last.
  always_comb begin
    d_eq = &w_bitEq;
    d_gt = 1'b0;
    for (int i = 0; i < DIGIT; i++) begin
      if (!w_bitEq[i]) begin
        d_gt = x[i];
      end
    end
  end

endmodule

// File: rtl/seq_mag_comparator.sv
// Multi-cycle magnitude comparator: scans operands DIGIT bits per cycle,
// MSB-first, and stops at the first differing slice.
module seq_mag_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [WIDTH-1:0]                         a,
  input  logic [WIDTH-1:0]                         b,
  input  logic                                     is_signed,
  input  logic [1:0]                               rel,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic                                     eq,
  output logic                                     gt,
  output logic                                     lt,
  output logic                                     result,
  output logic [$clog2(ndig(WIDTH, DIGIT)+1)-1:0]  cycles
);

  localparam int NDIG = ndig(WIDTH, DIGIT);
  localparam int PW   = NDIG * DIGIT;
  localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int CW   = $clog2(NDIG + 1);

  state_t           r_state;
  state_t           w_nextState;
  logic [PW-1:0]    r_a;
  logic [PW-1:0]    r_b;
  rel_t             r_rel;
  logic [IDXW-1:0]  r_idx;
  logic [CW-1:0]    r_cnt;
  logic             r_eq;
  logic             r_gt;
  logic             r_lt;

  logic [PW-1:0]    w_capA;
  logic [PW-1:0]    w_capB;
  logic [DIGIT-1:0] w_sliceA;
  logic [DIGIT-1:0] w_sliceB;
  logic             w_dEq;
  logic             w_dGt;
  logic             w_accept;

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_sliceA = r_a[r_idx*DIGIT +: DIGIT];
  assign w_sliceB = r_b[r_idx*DIGIT +: DIGIT];

  digit_cmp #(.DIGIT(DIGIT)) u_digitCmp (
    .x    (w_sliceA),
    .y    (w_sliceB),
    .d_eq (w_dEq),
    .d_gt (w_dGt)
  );

  // Zero-pad operands to whole slices; flipping the sign bit maps signed order onto unsigned order.
  always_comb begin
    w_capA = '0;
    w_capB = '0;
    w_capA[WIDTH-1:0] = a;
    w_capB[WIDTH-1:0] = b;
    w_capA[WIDTH-1] = a[WIDTH-1] ^ is_signed;
    w_capB[WIDTH-1] = b[WIDTH-1] ^ is_signed;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: leave SCAN on the first differing slice or after slice 0.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: if (in_valid) w_nextState = SCAN;
      SCAN: if (!w_dEq || (r_idx == '0)) w_nextState = DONE;
      DONE: if (out_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Operand capture and per-cycle scan bookkeeping; flags persist until the next capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_rel <= REL_EQ;
      r_idx <= '0;
      r_cnt <= '0;
      r_eq  <= 1'b0;
      r_gt  <= 1'b0;
      r_lt  <= 1'b0;
    end else if (w_accept) begin
      r_a   <= w_capA;
      r_b   <= w_capB;
      r_rel <= rel_t'(rel);
      r_idx <= IDXW'(NDIG - 1);
      r_cnt <= '0;
      r_eq  <= 1'b0;
      r_gt  <= 1'b0;
      r_lt  <= 1'b0;
    end else if (r_state == SCAN) begin
      r_cnt <= r_cnt + CW'(1);
      if (!w_dEq) begin
        r_gt <= w_dGt;
        r_lt <= !w_dGt;
      end else if (r_idx == '0) begin
        r_eq <= 1'b1;
      end else begin
        r_idx <= r_idx - IDXW'(1);
      end
    end
  end

  // Handshake outputs from state, result selected from the held flags.
  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    eq        = r_eq;
    gt        = r_gt;
    lt        = r_lt;
    cycles    = r_cnt;
    result    = 1'b0;
    case (r_rel)
      REL_EQ:  result = r_eq;
      REL_GT:  result = r_gt;
      REL_LT:  result = r_lt;
      REL_GE:  result = r_gt | r_eq;
      default: result = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Scoreboard bench for seq_mag_comparator: an 8-bit/2-bit and a 5-bit/2-bit instance.
module tb_seq_mag_comparator;

  typedef struct packed {
    logic       eq;
    logic       gt;
    logic       lt;
    logic       result;
    logic [3:0] cycles;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  logic       inValid8, outReady8, isSigned8;
  logic [7:0] a8, b8;
  logic [1:0] rel8;
  logic       inReady8, outValid8, eq8, gt8, lt8, result8;
  logic [2:0] cycles8;

  logic       inValid5, outReady5, isSigned5;
  logic [4:0] a5, b5;
  logic [1:0] rel5;
  logic       inReady5, outValid5, eq5, gt5, lt5, result5;
  logic [1:0] cycles5;

  int   numChecks = 0;
  int   numErrors = 0;
  exp_t scoreboard[$];

  always #5 clk = ~clk;

  seq_mag_comparator #(.WIDTH(8), .DIGIT(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid8), .in_ready(inReady8),
    .a(a8), .b(b8), .is_signed(isSigned8), .rel(rel8),
    .out_valid(outValid8), .out_ready(outReady8),
    .eq(eq8), .gt(gt8), .lt(lt8), .result(result8), .cycles(cycles8)
  );

  seq_mag_comparator #(.WIDTH(5), .DIGIT(2)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid5), .in_ready(inReady5),
    .a(a5), .b(b5), .is_signed(isSigned5), .rel(rel5),
    .out_valid(outValid5), .out_ready(outReady5),
    .eq(eq5), .gt(gt5), .lt(lt5), .result(result5), .cycles(cycles5)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    numChecks++;
    if (observed !== expected) begin
      numErrors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Reference: integer compare for the flags, explicit MSB-first digit walk for the cycle count.
  function automatic exp_t model(input int w, input logic [7:0] av, input logic [7:0] bv,
                                 input logic sgn, input logic [1:0] relv);
    exp_t e;
    int   mask, ia, ib, ua, ub, nd, k;
    mask = (1 << w) - 1;
    ia = int'(av) & mask;
    ib = int'(bv) & mask;
    ua = ia;
    ub = ib;
    if (sgn) begin
      if (((ia >> (w - 1)) & 1) == 1) ia = ia - (1 << w);
      if (((ib >> (w - 1)) & 1) == 1) ib = ib - (1 << w);
      ua = ua ^ (1 << (w - 1));
      ub = ub ^ (1 << (w - 1));
    end
    e.eq = (ia == ib);
    e.gt = (ia > ib);
    e.lt = (ia < ib);
    case (relv)
      2'd0:    e.result = e.eq;
      2'd1:    e.result = e.gt;
      2'd2:    e.result = e.lt;
      default: e.result = e.gt | e.eq;
    endcase
    nd = (w + 1) / 2;
    k = 0;
    for (int d = nd - 1; d >= 0; d--) begin
      k++;
      if (((ua >> (2 * d)) & 3) != ((ub >> (2 * d)) & 3)) break;
    end
    e.cycles = 4'(k);
    return e;
  endfunction

  task automatic sampleOutputs(input int inst, output logic v, output logic rdy, output exp_t o);
    if (inst == 0) begin
      v = outValid8; rdy = inReady8;
      o.eq = eq8; o.gt = gt8; o.lt = lt8; o.result = result8; o.cycles = 4'(cycles8);
    end else begin
      v = outValid5; rdy = inReady5;
      o.eq = eq5; o.gt = gt5; o.lt = lt5; o.result = result5; o.cycles = 4'(cycles5);
    end
  endtask

  task automatic checkFlags(input string tag, input exp_t o, input exp_t e);
    checkOutput({tag, "_eq"}, int'(o.eq), int'(e.eq));
    checkOutput({tag, "_gt"}, int'(o.gt), int'(e.gt));
    checkOutput({tag, "_lt"}, int'(o.lt), int'(e.lt));
    checkOutput({tag, "_result"}, int'(o.result), int'(e.result));
    checkOutput({tag, "_cycles"}, int'(o.cycles), int'(e.cycles));
  endtask

  task automatic checkIdleReset(input int inst);
    logic v, rdy;
    exp_t o;
    sampleOutputs(inst, v, rdy, o);
    checkOutput("rst_out_valid", int'(v), 0);
    checkOutput("rst_in_ready", int'(rdy), 1);
    checkFlags("rst", o, exp_t'(0));
  endtask

  // Drive one operand pair through the input handshake and record the expected result.
  task automatic applyStimulus(input int inst, input logic [7:0] av, input logic [7:0] bv,
                               input logic sgn, input logic [1:0] relv);
    logic v, rdy;
    exp_t o;
    @(negedge clk);
    sampleOutputs(inst, v, rdy, o);
    checkOutput("in_ready_before_accept", int'(rdy), 1);
    if (inst == 0) begin
      a8 = av; b8 = bv; isSigned8 = sgn; rel8 = relv; inValid8 = 1'b1;
    end else begin
      a5 = av[4:0]; b5 = bv[4:0]; isSigned5 = sgn; rel5 = relv; inValid5 = 1'b1;
    end
    scoreboard.push_back(model((inst == 0) ? 8 : 5, av, bv, sgn, relv));
    @(posedge clk);
    #1;
    inValid8 = 1'b0;
    inValid5 = 1'b0;
  endtask

  // Wait for the result, compare against the scoreboard, optionally stall, then hand it off.
  task automatic collectResult(input int inst, input int holdCycles);
    logic v, rdy;
    exp_t o, e;
    int   lat;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      sampleOutputs(inst, v, rdy, o);
      if (v) begin
        lat = n;
        break;
      end
    end
    if (lat == 0) begin
      checkOutput("out_valid_timeout", 0, 1);
      scoreboard.delete();
      return;
    end
    e = scoreboard.pop_front();
    checkOutput("latency", lat, int'(e.cycles));
    checkOutput("in_ready_done", int'(rdy), 0);
    checkFlags("res", o, e);
    for (int h = 0; h < holdCycles; h++) begin
      @(negedge clk);
      if (inst == 0) begin
        a8 = ~a8; b8 = 8'h00; inValid8 = 1'b1;
      end else begin
        a5 = ~a5; b5 = 5'h00; inValid5 = 1'b1;
      end
      @(posedge clk);
      #1;
      inValid8 = 1'b0;
      inValid5 = 1'b0;
      sampleOutputs(inst, v, rdy, o);
      checkOutput("hold_out_valid", int'(v), 1);
      checkOutput("hold_in_ready", int'(rdy), 0);
      checkFlags("hold", o, e);
    end
    @(negedge clk);
    if (inst == 0) outReady8 = 1'b1; else outReady5 = 1'b1;
    @(posedge clk);
    #1;
    outReady8 = 1'b0;
    outReady5 = 1'b0;
    sampleOutputs(inst, v, rdy, o);
    checkOutput("post_hs_out_valid", int'(v), 0);
    checkOutput("post_hs_in_ready", int'(rdy), 1);
    checkFlags("post_hs", o, e);
  endtask

  initial begin
    logic v, rdy;
    exp_t o;
    rst_n = 1'b0;
    inValid8 = 0; outReady8 = 0; isSigned8 = 0; a8 = 0; b8 = 0; rel8 = 0;
    inValid5 = 0; outReady5 = 0; isSigned5 = 0; a5 = 0; b5 = 0; rel5 = 0;
    #23;
    checkIdleReset(0);
    checkIdleReset(1);
    @(negedge clk);
    rst_n = 1'b1;
    $display("[TB] directed operations");

    applyStimulus(0, 8'h80, 8'h7F, 1'b0, 2'd1);
    collectResult(0, 0);
    applyStimulus(0, 8'h80, 8'h7F, 1'b1, 2'd2);
    collectResult(0, 0);
    applyStimulus(0, 8'h5A, 8'h5A, 1'b0, 2'd3);
    collectResult(0, 0);
    applyStimulus(0, 8'h5B, 8'h5A, 1'b0, 2'd1);
    collectResult(0, 5);
    applyStimulus(0, 8'h12, 8'h34, 1'b0, 2'd0);
    collectResult(0, 0);
    applyStimulus(1, 8'h10, 8'h0F, 1'b0, 2'd1);
    collectResult(1, 0);
    applyStimulus(1, 8'h15, 8'h15, 1'b0, 2'd0);
    collectResult(1, 0);
    applyStimulus(1, 8'h10, 8'h0F, 1'b1, 2'd3);
    collectResult(1, 2);

    $display("[TB] reset during scan");
    applyStimulus(0, 8'h5B, 8'h5A, 1'b0, 2'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    scoreboard.delete();
    checkIdleReset(0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk);
      #1;
      sampleOutputs(0, v, rdy, o);
      checkOutput("abort_out_valid", int'(v), 0);
    end
    checkIdleReset(0);

    $display("[TB] random operations");
    for (int i = 0; i < 24; i++) begin
      int inst;
      logic [7:0] ra, rb;
      inst = int'($urandom_range(0, 1));
      ra = 8'($urandom);
      rb = (i % 4 == 0) ? ra : 8'($urandom);
      if (i % 5 == 1) rb = ra ^ 8'h01;
      applyStimulus(inst, ra, rb, 1'($urandom), 2'($urandom));
      collectResult(inst, i % 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got 1, expected 0");
    $fatal(1, "[TB] simulation did not complete");
  end

endmodule

// File: doc/seq_mag_comparator.md
Name: seq_mag_comparator

Overview:
Parametrised, multi-cycle magnitude comparator. It is the successor to the combinational 1-/2-bit equality comparators.
- Accepts two WIDTH-bit operands through a valid/ready handshake.
- Compares them DIGIT bits per cycle, MSB-first, and stops early at the first differing digit.
- Returns eq/gt/lt flags, the selected relation result and the number of digit cycles used.
- Sits between the switch/operand capture logic and the LED/result display path.

Parameters:
- WIDTH, 8, operand width in bits (>=1).
- DIGIT, 2, bits compared per cycle (1..WIDTH).
- NDIG, ceil(WIDTH/DIGIT) (derived localparam, not overridable), number of digit slices.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands and mode are valid.
- in_ready  out  1  block can accept an operand pair.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- is_signed  in  1  1 = two's-complement compare, 0 = unsigned.
- rel  in  2  relation select: 0=EQ, 1=GT, 2=LT, 3=GE.
- out_valid  out  1  result fields valid.
- out_ready  in  1  consumer accepts the result.
- eq  out  1  a == b.
- gt  out  1  a > b.
- lt  out  1  a < b.
- result  out  1  relation selected by rel, evaluated on eq/gt/lt.
- cycles  out  clog2(NDIG+1)  digit cycles consumed (1..NDIG).

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE.
  - in_ready=1, out_valid=0.
  - eq, gt, lt, result and cycles = 0.
  - All internal registers are cleared.
- States: IDLE, SCAN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at a clock edge, capture a, b and rel into registers.
  - If is_signed=1, invert bit WIDTH-1 of both captured operands. An unsigned compare of the result is then equivalent to the signed compare.
  - Zero-extend both captured operands to NDIG*DIGIT bits at the MSB end.
  - Set digit index idx=NDIG-1 and cnt=0, then go to SCAN.
- SCAN:
  - in_ready=0.
  - Each cycle, compare slice idx of A against slice idx of B; cnt increments.
  - If the slices differ, set gt or lt from that slice, clear eq, and go to DONE.
  - Else if idx==0, set eq=1 and go to DONE.
  - Else decrement idx and stay in SCAN.
- DONE:
  - out_valid=1; eq, gt, lt, result and cycles (= cnt) are held stable.
  - in_ready=0.
  - On out_ready=1, go to IDLE and clear out_valid on the same edge. The flags keep their last values until the next capture.
- Latency: the first SCAN cycle immediately follows the accept edge; out_valid rises k cycles after the accept edge.
  - k = number of digits examined, 1..NDIG.
  - Maximum k = NDIG when the operands are equal or differ only in slice 0.
- Throughput: one operation in flight, no pipelining. A new accept is possible at the earliest one cycle after the result handshake.
- Result mapping: EQ=eq, GT=gt, LT=lt, GE=gt|eq. Exactly one of eq/gt/lt is 1 whenever out_valid=1.
- in_valid while busy: ignored. The operands are not sampled, and in_valid is not required to be held.
- out_ready while out_valid=0: ignored.
- Reset asserted mid-SCAN or in DONE: the operation is aborted, reset values apply immediately, and no result is produced.
- WIDTH not a multiple of DIGIT: the top slice is partially padded. Padding is zero on both operands, so it never creates a difference.
- DIGIT==WIDTH: single-cycle SCAN, cycles=1 always.

Decomposition:
- Package cmp_pkg holds:
  - typedef enum state_t {IDLE, SCAN, DONE};
  - typedef enum rel_t {REL_EQ, REL_GT, REL_LT, REL_GE} (2-bit).
  - function ndig(width, digit) returning the ceiling division.
- One sub-module, digit_cmp #(DIGIT).
  - Combinational; inputs x, y [DIGIT-1:0]; outputs d_eq, d_gt.
  - Built from per-bit equality (xnor) with MSB-first priority.
- The top level holds the FSM, operand registers, idx/cnt counters and the handshake.

Test Plan:
1. WIDTH=8, DIGIT=2, unsigned: a=0x80, b=0x7F, rel=GT -> out_valid 1 cycle after accept; gt=1, result=1, cycles=1.
2. Same operands with is_signed=1, rel=LT -> lt=1 (-128 < 127), result=1, cycles=1.
3. a=b=0x5A, rel=GE -> eq=1, gt=0, lt=0, result=1, cycles=4; a=0x5B, b=0x5A -> gt=1, cycles=4.
4. out_ready held 0 for 5 cycles after out_valid -> all outputs stable and in_ready=0 throughout; in_valid pulses during that time are ignored; the next op is accepted after the handshake.
5. WIDTH=5, DIGIT=2 (NDIG=3): a=5'b10000, b=5'b01111 unsigned -> gt=1, cycles=1; a=b=5'h15 -> eq=1, cycles=3.
6. a=0x5B, b=0x5A, rst_n pulled low during the 2nd SCAN cycle -> out_valid never asserts; after release, in_ready=1 and all outputs are 0.
